// File: rtl/fpu_pkg.sv
// +--------------------------------------------------------------------------+
// | fpu_pkg: shared types, status bit indices and field helpers for the FPU  |
// | Rev 1.0  - initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5,
    S_DONE   = 3'd6
  } fpu_state_t;

  localparam int ST_EXACT   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_INEXACT = 3;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Words are passed zero-extended to 64 bits so one helper serves any width.
  function automatic logic is_zero(input logic [63:0] word, input int exp_w, input int man_w);
    logic [63:0] mask;
    mask = (64'd1 << exp_w) - 64'd1;
    return ((word >> man_w) & mask) == 64'd0;
  endfunction

  function automatic logic is_inf(input logic [63:0] word, input int exp_w, input int man_w);
    logic [63:0] mask;
    mask = (64'd1 << exp_w) - 64'd1;
    return ((word >> man_w) & mask) == mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_rounder.sv
// +--------------------------------------------------------------------------+
// | fpu_rounder: fraction + G/R/S -> rounded fraction, carry and inexact.    |
// | FPU_ROUND_NEAREST_EN selects round-to-nearest-even, else truncation.     |
// | Rev 1.0  - initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module fpu_rounder #(
  parameter int MAN_W = 21
) (
  input  logic [MAN_W-1:0] frac_i,
  input  logic             g_i,
  input  logic             r_i,
  input  logic             s_i,
  output logic [MAN_W-1:0] frac_o,
  output logic             carry_o,
  output logic             inexact_o
);

  logic round_up;

`ifdef FPU_ROUND_NEAREST_EN
  assign round_up = g_i & (r_i | s_i | frac_i[0]);
`else
  assign round_up = 1'b0;
`endif

  // A carry out of the fraction means the mantissa became 10.000..: caller bumps exp.
  assign {carry_o, frac_o} = {1'b0, frac_i} + {{MAN_W{1'b0}}, round_up};
  assign inexact_o = g_i | r_i | s_i;

endmodule

`default_nettype wire

// File: rtl/fpu_addsub_param.sv
// +--------------------------------------------------------------------------+
// | fpu_addsub_param: parametrised multicycle FP adder/subtractor with       |
// | valid/ready handshakes; rounding mode via FPU_ROUND_NEAREST_EN.          |
// | Rev 1.0  - initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 10,
  parameter  int MAN_W = 21,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100KHz,
  input  logic         reset,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic         op_sub_in,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  // Working mantissa: {carry, hidden, fraction, G, R, S}
  localparam int MW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] COLLAPSE = EXP_W'(MAN_W + 3);

  fpu_state_t state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]            st_q, st_d;
  logic                  sign_q, sign_d, esub_q, esub_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic [EXP_W-1:0]      diff_q, diff_d;
  logic [MW:0]           xm_q, xm_d, ym_q, ym_d;

  logic                  a_s, b_s, a_ge_b, a_inf, b_inf, a_zero, b_zero;
  logic [W-1:0]          x_w, y_w;
  logic [MW:0]           sum;
  logic [MAN_W-1:0]      rnd_frac;
  logic                  rnd_carry, rnd_inexact;
  logic signed [XW-1:0]  exp_r;

  assign a_s    = a_q[W-1];
  assign b_s    = b_q[W-1];
  assign a_ge_b = a_q[W-2:0] >= b_q[W-2:0];
  assign x_w    = a_ge_b ? a_q : b_q;
  assign y_w    = a_ge_b ? b_q : a_q;
  assign a_inf  = is_inf(64'(a_q), EXP_W, MAN_W);
  assign b_inf  = is_inf(64'(b_q), EXP_W, MAN_W);
  assign a_zero = is_zero(64'(a_q), EXP_W, MAN_W);
  assign b_zero = is_zero(64'(b_q), EXP_W, MAN_W);
  assign sum    = esub_q ? (xm_q - ym_q) : (xm_q + ym_q);
  assign exp_r  = exp_q + $signed({{(XW-1){1'b0}}, rnd_carry});

  fpu_rounder #(.MAN_W(MAN_W)) u_rounder (
    .frac_i    (xm_q[MW-2:3]),
    .g_i       (xm_q[2]),
    .r_i       (xm_q[1]),
    .s_i       (xm_q[0]),
    .frac_o    (rnd_frac),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      st_q    <= '0;
      sign_q  <= 1'b0;
      esub_q  <= 1'b0;
      exp_q   <= '0;
      diff_q  <= '0;
      xm_q    <= '0;
      ym_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      st_q    <= st_d;
      sign_q  <= sign_d;
      esub_q  <= esub_d;
      exp_q   <= exp_d;
      diff_q  <= diff_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    st_d    = st_q;
    sign_d  = sign_q;
    esub_d  = esub_q;
    exp_d   = exp_q;
    diff_d  = diff_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          a_d     = op_A_in;
          b_d     = {op_B_in[W-1] ^ op_sub_in, op_B_in[W-2:0]};
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        state_d = S_DONE;
        if (a_inf && b_inf && (a_s != b_s)) begin
          res_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
          st_d  = 4'b1010;
        end else if (a_inf) begin
          res_d = {a_s, EXP_ONES, {MAN_W{1'b0}}};
          st_d  = 4'b0010;
        end else if (b_inf) begin
          res_d = {b_s, EXP_ONES, {MAN_W{1'b0}}};
          st_d  = 4'b0010;
        end else if (a_zero) begin
          res_d = b_q;
          st_d  = 4'b0001;
        end else if (b_zero) begin
          res_d = a_q;
          st_d  = 4'b0001;
        end else begin
          sign_d  = x_w[W-1];
          esub_d  = a_s ^ b_s;
          exp_d   = $signed({2'b00, x_w[W-2:MAN_W]});
          diff_d  = x_w[W-2:MAN_W] - y_w[W-2:MAN_W];
          xm_d    = {2'b01, x_w[MAN_W-1:0], 3'b000};
          ym_d    = {2'b01, y_w[MAN_W-1:0], 3'b000};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (diff_q == '0) begin
          state_d = S_ADD;
        end else if (diff_q > COLLAPSE) begin
          ym_d    = {{MW{1'b0}}, 1'b1};
          diff_d  = '0;
          state_d = S_ADD;
        end else begin
          ym_d   = {1'b0, ym_q[MW:2], ym_q[1] | ym_q[0]};
          diff_d = diff_q - 1'b1;
          if (diff_q == 1) state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (sum == '0) begin
          res_d   = '0;
          st_d    = 4'b0001;
          state_d = S_DONE;
        end else begin
          xm_d    = sum;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (xm_q[MW]) begin
          xm_d    = {1'b0, xm_q[MW:2], xm_q[1] | xm_q[0]};
          exp_d   = exp_q + 1;
          state_d = S_ROUND;
        end else if (!xm_q[MW-1]) begin
          xm_d  = xm_q << 1;
          exp_d = exp_q - 1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (exp_r >= $signed({2'b00, EXP_ONES})) begin
          res_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          st_d  = 4'b1010;
        end else if (exp_r <= $signed({XW{1'b0}})) begin
          res_d = '0;
          st_d  = 4'b1100;
        end else begin
          res_d = {sign_q, exp_r[EXP_W-1:0], rnd_frac};
          st_d  = rnd_inexact ? 4'b1000 : 4'b0001;
        end
      end
      S_DONE: begin
        if (ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_out  = (state_q == S_IDLE);
  assign valid_out  = (state_q == S_DONE);
  assign data_out   = res_q;
  assign status_out = st_q;

endmodule

`default_nettype wire
